// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Pipeline write-back stage with memory-wait FSM, sticky
//                timeout detection and stall/retirement counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int REGISTER_LEN    = 32,
    parameter int REG_ADDRESS_LEN = 4,
    parameter int CNT_LEN         = 16,
    parameter int TIMEOUT         = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en_in,
    input  logic                       mem_r_en_in,
    input  logic                       mem_w_en_in,
    input  logic [REGISTER_LEN-1:0]    alu_res_in,
    input  logic [REGISTER_LEN-1:0]    mem_out_in,
    input  logic [REG_ADDRESS_LEN-1:0] dest_in,
    input  logic                       mem_ready,
    output logic                       freeze,
    output logic                       wb_en,
    output logic [REG_ADDRESS_LEN-1:0] wb_dest,
    output logic [REGISTER_LEN-1:0]    wb_value,
    output logic                       mem_timeout,
    output logic [CNT_LEN-1:0]         stall_cnt,
    output logic [CNT_LEN-1:0]         retired_cnt
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [WAIT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                       wb_en_q, wb_en_d;
    logic [REG_ADDRESS_LEN-1:0] wb_dest_q, wb_dest_d;
    logic [REGISTER_LEN-1:0]    wb_value_q, wb_value_d;
    logic                       timeout_q, timeout_d;
    logic [CNT_LEN-1:0]         stall_cnt_q, stall_cnt_d;
    logic [CNT_LEN-1:0]         retired_cnt_q, retired_cnt_d;

    logic w_accept;
    logic w_in_wait;
    logic w_mem_op;

    assign w_mem_op = mem_r_en_in | mem_w_en_in;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!mem_ready && w_mem_op) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (an accept is any ready cycle, in either state)
    // ------------------------------------------------------------------
    always_comb begin
        w_accept  = mem_ready;
        w_in_wait = 1'b0;
        case (state_q)
            S_IDLE:  w_in_wait = 1'b0;
            S_WAIT:  w_in_wait = 1'b1;
            default: w_in_wait = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        wb_en_d       = 1'b0;
        wb_dest_d     = wb_dest_q;
        wb_value_d    = wb_value_q;
        wait_cnt_d    = '0;
        timeout_d     = timeout_q;
        stall_cnt_d   = stall_cnt_q;
        retired_cnt_d = retired_cnt_q;

        if (w_accept) begin
            wb_en_d    = wb_en_in;
            wb_dest_d  = dest_in;
            // A simultaneous read+write is treated as a load.
            wb_value_d = mem_r_en_in ? mem_out_in : alu_res_in;
            if (wb_en_in || mem_w_en_in) begin
                retired_cnt_d = retired_cnt_q + CNT_LEN'(1);
            end
        end else begin
            if (stall_cnt_q != {CNT_LEN{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_LEN'(1);
            end
        end

        // Counter holds at its last value so it cannot wrap during a long wait.
        if (w_in_wait && !mem_ready) begin
            if (wait_cnt_q == C_WAIT_LAST) begin
                wait_cnt_d = wait_cnt_q;
                timeout_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            wb_en_q       <= 1'b0;
            wb_dest_q     <= '0;
            wb_value_q    <= '0;
            timeout_q     <= 1'b0;
            stall_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            wb_en_q       <= wb_en_d;
            wb_dest_q     <= wb_dest_d;
            wb_value_q    <= wb_value_d;
            timeout_q     <= timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign freeze      = ~mem_ready;
    assign wb_en       = wb_en_q;
    assign wb_dest     = wb_dest_q;
    assign wb_value    = wb_value_q;
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign retired_cnt = retired_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_stage
//  Description : Directed self-checking bench for wb_stage (TIMEOUT=4,
//                CNT_LEN=4 so timeout and counter limits are reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int REGISTER_LEN    = 32;
    localparam int REG_ADDRESS_LEN = 4;
    localparam int CNT_LEN         = 4;
    localparam int TIMEOUT         = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       wb_en_in;
    logic                       mem_r_en_in;
    logic                       mem_w_en_in;
    logic [REGISTER_LEN-1:0]    alu_res_in;
    logic [REGISTER_LEN-1:0]    mem_out_in;
    logic [REG_ADDRESS_LEN-1:0] dest_in;
    logic                       mem_ready;
    logic                       freeze;
    logic                       wb_en;
    logic [REG_ADDRESS_LEN-1:0] wb_dest;
    logic [REGISTER_LEN-1:0]    wb_value;
    logic                       mem_timeout;
    logic [CNT_LEN-1:0]         stall_cnt;
    logic [CNT_LEN-1:0]         retired_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    wb_stage #(
        .REGISTER_LEN    (REGISTER_LEN),
        .REG_ADDRESS_LEN (REG_ADDRESS_LEN),
        .CNT_LEN         (CNT_LEN),
        .TIMEOUT         (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en_in    (wb_en_in),
        .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in),
        .alu_res_in  (alu_res_in),
        .mem_out_in  (mem_out_in),
        .dest_in     (dest_in),
        .mem_ready   (mem_ready),
        .freeze      (freeze),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .mem_timeout (mem_timeout),
        .stall_cnt   (stall_cnt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic wr,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [3:0] dst, input logic rdy);
        wb_en_in    = we;
        mem_r_en_in = re;
        mem_w_en_in = wr;
        alu_res_in  = alu;
        mem_out_in  = mem;
        dest_in     = dst;
        mem_ready   = rdy;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b1);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_wb_dest", 32'(wb_dest), 32'd0);
        check("rst_wb_value", wb_value, 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_retired", 32'(retired_cnt), 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);

        // ALU op, one-cycle latency
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'hDEAD, 4'd5, 1'b1);
        step();
        check("alu_wb_en", 32'(wb_en), 32'd1);
        check("alu_dest", 32'(wb_dest), 32'd5);
        check("alu_value", wb_value, 32'h1234);
        check("alu_retired", 32'(retired_cnt), 32'd1);

        // Load with 3 stall cycles
        drive(1'b1, 1'b1, 1'b0, 32'h1111, 32'hCAFE, 4'd7, 1'b0);
        check("ld_freeze_on", 32'(freeze), 32'd1);
        step();
        check("ld_bubble", 32'(wb_en), 32'd0);
        check("ld_hold_dest", 32'(wb_dest), 32'd5);
        check("ld_hold_value", wb_value, 32'h1234);
        step();
        step();
        check("ld_bubble3", 32'(wb_en), 32'd0);
        check("ld_freeze3", 32'(freeze), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h1111, 32'hCAFE, 4'd7, 1'b1);
        check("ld_freeze_off", 32'(freeze), 32'd0);
        step();
        check("ld_wb_en", 32'(wb_en), 32'd1);
        check("ld_value", wb_value, 32'hCAFE);
        check("ld_dest", 32'(wb_dest), 32'd7);
        check("ld_stall", 32'(stall_cnt), 32'd3);
        check("ld_retired", 32'(retired_cnt), 32'd2);
        check("ld_no_timeout", 32'(mem_timeout), 32'd0);

        // Back-to-back alternating load / ALU
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i % 2 == 0), 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i), 4'(i + 1), 1'b1);
            step();
            check("b2b_wb_en", 32'(wb_en), 32'd1);
            check("b2b_value", wb_value, (i % 2 == 0) ? 32'h200 + 32'(i) : 32'h100 + 32'(i));
            check("b2b_dest", 32'(wb_dest), 32'(i + 1));
        end
        check("b2b_retired", 32'(retired_cnt), 32'd6);

        // Load without write-back: data updates, no write enable, no retire
        drive(1'b0, 1'b1, 1'b0, 32'h55, 32'h66, 4'd9, 1'b1);
        step();
        check("ldnw_wb_en", 32'(wb_en), 32'd0);
        check("ldnw_value", wb_value, 32'h66);
        check("ldnw_dest", 32'(wb_dest), 32'd9);
        check("ldnw_retired", 32'(retired_cnt), 32'd6);

        // Read and write both high: load data, one retirement
        drive(1'b0, 1'b1, 1'b1, 32'h77, 32'h88, 4'd3, 1'b1);
        step();
        check("rw_value", wb_value, 32'h88);
        check("rw_retired", 32'(retired_cnt), 32'd7);

        // Stall with no memory op stays IDLE: 5 cycles, no timeout
        drive(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 4'd2, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("nop_stall_bubble", 32'(wb_en), 32'd0);
        check("nop_stall_hold", wb_value, 32'h88);
        check("nop_stall_cnt", 32'(stall_cnt), 32'd8);
        check("nop_no_timeout", 32'(mem_timeout), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 4'd2, 1'b1);
        step();
        check("nop_accept_value", wb_value, 32'h99);
        check("nop_retired", 32'(retired_cnt), 32'd8);

        // Store timeout: IDLE stall cycle, then 4 WAIT cycles
        drive(1'b0, 1'b0, 1'b1, 32'hAA, 32'h0, 4'd4, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("to_not_yet", 32'(mem_timeout), 32'd0);
        step();
        check("to_set", 32'(mem_timeout), 32'd1);
        check("to_stall", 32'(stall_cnt), 32'd13);
        drive(1'b0, 1'b0, 1'b1, 32'hAA, 32'h0, 4'd4, 1'b1);
        step();
        check("to_sticky", 32'(mem_timeout), 32'd1);
        check("to_store_value", wb_value, 32'hAA);
        check("to_retired", 32'(retired_cnt), 32'd9);

        // Stall counter saturation
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("stall_sat", 32'(stall_cnt), 32'd15);

        // Reset on second stall cycle of a load
        drive(1'b1, 1'b1, 1'b0, 32'h1, 32'hBEEF, 4'd6, 1'b1);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h2, 32'hF00D, 4'd8, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_freeze", 32'(freeze), 32'd1);
        step();
        rst = 1'b0;
        check("mid_rst_wb_en", 32'(wb_en), 32'd0);
        check("mid_rst_dest", 32'(wb_dest), 32'd0);
        check("mid_rst_value", wb_value, 32'd0);
        check("mid_rst_timeout", 32'(mem_timeout), 32'd0);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check("mid_rst_retired", 32'(retired_cnt), 32'd0);
        check("mid_rst_freeze2", 32'(freeze), 32'd1);
        // Restart from IDLE: 1 IDLE + 3 WAIT cycles must not time out yet
        for (int i = 0; i < 4; i++) step();
        check("post_rst_idle", 32'(mem_timeout), 32'd0);
        check("post_rst_stall", 32'(stall_cnt), 32'd4);
        step();
        check("post_rst_timeout", 32'(mem_timeout), 32'd1);

        // Retired counter wrap after 16 retirements from 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(i), 32'h0, 4'd1, 1'b1);
            step();
        end
        check("ret_15", 32'(retired_cnt), 32'd15);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd1, 1'b1);
        step();
        check("ret_wrap", 32'(retired_cnt), 32'd0);
        check("ret_no_stall", 32'(stall_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
